// File: rtl/velest_pkg.sv
// velest_pkg: FSM state type and width helpers shared by the velocity estimator.
package velest_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    function automatic int diff_w(input int w);
        return w + 1;
    endfunction
    function automatic int sum_w(input int w, input int avg_log2);
        return w + 1 + avg_log2;
    endfunction
    function automatic int prod_w(input int w, input int avg_log2, input int scale_num);
        return sum_w(w, avg_log2) + $clog2(scale_num + 1);
    endfunction
endpackage

// File: rtl/velocity_estimator_if.sv
// velocity_estimator_if: position-sample in / velocity-strobe out bus.
interface velocity_estimator_if #(parameter int W = 16);
    logic i_clear, i_valid, o_valid, o_err, o_ready;
    logic [W-1:0] i_value, o_value;
    modport master (output i_clear, i_valid, i_value, input o_valid, o_value, o_err, o_ready);
    modport slave (input i_clear, i_valid, i_value, output o_valid, o_value, o_err, o_ready);
endinterface

// File: rtl/velest_moddiff.sv
// velest_moddiff: registered wrap-aware signed difference between successive positions.
module velest_moddiff
    import velest_pkg::*;
#(
    parameter int W = 16,
    parameter int MODULUS = 1496
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    load,
    input  logic [W-1:0]            value,
    output logic signed [W:0]       diff
);
    localparam int DW = diff_w(W);
    localparam logic signed [DW-1:0] MOD = DW'(MODULUS);
    localparam logic signed [DW-1:0] HALF = DW'(MODULUS / 2);
    logic [W-1:0] prev;
    logic signed [DW-1:0] raw, wrapped;
    always_comb begin
        raw = $signed({1'b0, value}) - $signed({1'b0, prev});
        wrapped = raw > HALF ? raw - MOD : raw < -HALF ? raw + MOD : raw;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prev <= '0;
            diff <= '0;
        end else if (load) begin
            prev <= value;
            diff <= wrapped;
        end
    end
endmodule

// File: rtl/velocity_estimator.sv
// velocity_estimator: encoder position -> averaged, scaled signed velocity.
// Define VELEST_SATURATE_EN to clamp the output instead of wrapping it.
module velocity_estimator
    import velest_pkg::*;
#(
    parameter int W = 16,
    parameter int MODULUS = 1496,
    parameter int AVG_LOG2 = 2,
    parameter int SCALE_NUM = 29,
    parameter int SCALE_SHIFT = 3
) (
    input logic                i_clk,
    input logic                i_reset,
    velocity_estimator_if.slave bus
);
    localparam int N = 1 << AVG_LOG2;
    localparam int DW = diff_w(W);
    localparam int SW = sum_w(W, AVG_LOG2);
    localparam int PW = prod_w(W, AVG_LOG2, SCALE_NUM);
    localparam int CW = AVG_LOG2 + 1;
    localparam int PTRW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam logic signed [PW-1:0] K = PW'(SCALE_NUM);
    localparam logic signed [PW-1:0] VMAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] VMIN = ~VMAX;
    logic in_valid, in_clear, in_err, err_q;
    logic [W-1:0] in_value;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic last, d_valid, d_run, s_valid, o_valid_q;
    logic signed [DW-1:0] diff;
    logic signed [DW-1:0] ring [N];
    logic [PTRW-1:0] ptr;
    logic signed [SW-1:0] sum, avg;
    logic signed [PW-1:0] prod, vel;
    logic signed [W-1:0] vel_w, o_value_q;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            {in_valid, in_err, in_clear, err_q} <= '0;
            in_value <= '0;
        end else begin
            in_valid <= bus.i_valid && bus.i_value < W'(MODULUS);
            in_err <= bus.i_valid && bus.i_value >= W'(MODULUS);
            in_clear <= bus.i_clear;
            in_value <= bus.i_value;
            err_q <= in_err;
        end
    end
    // last: this accepted sample supplies the N-th diff, or the window is already full
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        last = state == RUN || (state == FILL && cnt == CW'(N - 1));
        if (in_clear) begin
            state_n = in_valid ? FILL : IDLE;
            cnt_n = '0;
        end else if (in_valid) begin
            state_n = state == IDLE ? FILL : last ? RUN : FILL;
            cnt_n = state == FILL && !last ? cnt + 1'b1 : cnt;
        end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= '0;
            d_valid <= 1'b0;
            d_run <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            d_valid <= in_valid && !in_clear && state != IDLE;
            d_run <= last;
        end
    end
    velest_moddiff #(.W(W), .MODULUS(MODULUS)) u_moddiff (
        .i_clk(i_clk), .i_reset(i_reset), .load(in_valid), .value(in_value), .diff(diff)
    );
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ring <= '{default: '0};
            ptr <= '0;
            sum <= '0;
            s_valid <= 1'b0;
        end else if (in_clear) begin
            ring <= '{default: '0};
            ptr <= '0;
            sum <= '0;
            s_valid <= 1'b0;
        end else begin
            s_valid <= d_valid && d_run;
            if (d_valid) begin
                ring[ptr] <= diff;
                ptr <= ptr == PTRW'(N - 1) ? '0 : ptr + 1'b1;
                sum <= sum + SW'(diff) - SW'(ring[ptr]);
            end
        end
    end
    always_comb begin
        avg = sum >>> AVG_LOG2;
        prod = PW'(avg) * K;
        vel = prod >>> SCALE_SHIFT;
    end
`ifdef VELEST_SATURATE_EN
    assign vel_w = vel > VMAX ? W'(VMAX) : vel < VMIN ? W'(VMIN) : W'(vel);
`else
    assign vel_w = W'(vel);
`endif
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid_q <= 1'b0;
            o_value_q <= '0;
        end else begin
            o_valid_q <= s_valid && !in_clear;
            if (s_valid && !in_clear) o_value_q <= vel_w;
        end
    end
    assign bus.o_valid = o_valid_q;
    assign bus.o_value = o_value_q;
    assign bus.o_err = err_q;
    assign bus.o_ready = state == RUN;
endmodule

// File: tb/tb_velocity_estimator.sv
// tb_velocity_estimator: directed checks of velocity_estimator, default and 400/0 scaling.
module tb_velocity_estimator;
    import velest_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    int tests = 0, fails = 0, nv = 0, lastv = 0, snv = 0, slast = 0, nerr = 0;
    int c;
    always #5 clk = ~clk;
    velocity_estimator_if #(.W(16)) vif ();
    velocity_estimator_if #(.W(16)) sif ();
    velocity_estimator dut (.i_clk(clk), .i_reset(rst), .bus(vif.slave));
    velocity_estimator #(.SCALE_NUM(400), .SCALE_SHIFT(0)) sat (.i_clk(clk), .i_reset(rst), .bus(sif.slave));
    assign sif.i_clear = vif.i_clear;
    assign sif.i_valid = vif.i_valid;
    assign sif.i_value = vif.i_value;
    always @(negedge clk) begin
        if (vif.o_valid) begin
            nv++;
            lastv = int'(vif.o_value);
        end
        if (sif.o_valid) begin
            snv++;
            slast = int'(sif.o_value);
        end
        if (vif.o_err) nerr++;
    end
    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask
    task automatic send(input int v);
        @(negedge clk);
        vif.i_valid = 1'b1;
        vif.i_value = 16'(v);
        @(negedge clk);
        vif.i_valid = 1'b0;
    endtask
    task automatic do_clear();
        @(negedge clk);
        vif.i_clear = 1'b1;
        @(negedge clk);
        vif.i_clear = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        vif.i_clear = 1'b0;
        vif.i_valid = 1'b0;
        vif.i_value = '0;
        idle(3);
        chk("rst_o_valid", int'(vif.o_valid), 0);
        chk("rst_o_value", int'(vif.o_value), 0);
        chk("rst_o_err", int'(vif.o_err), 0);
        chk("rst_o_ready", int'(vif.o_ready), 0);
        chk("rst_state", int'(dut.state), int'(IDLE));
        rst = 1'b0;
        idle(2);
        // constant speed, exact latency on the 5th sample
        send(0); send(10); send(20); send(30);
        idle(4);
        chk("const_no_out", nv, 0);
        chk("const_not_ready", int'(vif.o_ready), 0);
        @(negedge clk);
        vif.i_valid = 1'b1;
        vif.i_value = 16'd40;
        @(negedge clk);
        vif.i_valid = 1'b0;
        @(negedge clk);
        chk("const_ready", int'(vif.o_ready), 1);
        @(negedge clk);
        chk("const_lat_e2", int'(vif.o_valid), 0);
        @(negedge clk);
        chk("const_lat_e3", int'(vif.o_valid), 1);
        chk("const_value", int'(vif.o_value), 36);
        idle(3);
        chk("const_count", nv, 1);
        chk("const_hold", int'(vif.o_value), 36);
        // forward wrap across the modulus
        do_clear();
        idle(2);
        chk("clear_ready", int'(vif.o_ready), 0);
        c = nv;
        send(1450); send(1460); send(1470); send(1480); send(1490);
        idle(4);
        chk("wrap_first", lastv, 36);
        send(4);
        idle(4);
        chk("wrap_count", nv - c, 2);
        chk("wrap_value", lastv, 36);
        // reverse direction
        do_clear();
        c = nv;
        send(40); send(30); send(20); send(10); send(0);
        idle(4);
        chk("rev_count", nv - c, 1);
        chk("rev_value", lastv, 'hFFDB);
        // rejected sample mid-stream
        do_clear();
        send(0); send(10); send(30); send(60); send(100);
        idle(4);
        chk("err_pre_value", lastv, 90);
        c = nv;
        @(negedge clk);
        vif.i_valid = 1'b1;
        vif.i_value = 16'd1496;
        @(negedge clk);
        vif.i_valid = 1'b0;
        chk("err_e0", int'(vif.o_err), 0);
        @(negedge clk);
        chk("err_e1", int'(vif.o_err), 1);
        @(negedge clk);
        chk("err_e2", int'(vif.o_err), 0);
        idle(4);
        chk("err_no_out", nv - c, 0);
        chk("err_pulses", nerr, 1);
        chk("err_ready", int'(vif.o_ready), 1);
        send(150);
        idle(4);
        chk("err_next_value", lastv, 126);
        // clear+valid in RUN kills two in-flight samples
        c = nv;
        @(negedge clk);
        vif.i_valid = 1'b1;
        vif.i_value = 16'd160;
        @(negedge clk);
        vif.i_value = 16'd170;
        @(negedge clk);
        vif.i_value = 16'd200;
        vif.i_clear = 1'b1;
        @(negedge clk);
        vif.i_valid = 1'b0;
        vif.i_clear = 1'b0;
        idle(6);
        chk("clr_killed", nv - c, 0);
        chk("clr_ready", int'(vif.o_ready), 0);
        chk("clr_state", int'(dut.state), int'(FILL));
        send(210); send(220); send(230);
        idle(4);
        chk("clr_fill_no_out", nv - c, 0);
        send(240);
        idle(4);
        chk("clr_count", nv - c, 1);
        chk("clr_value", lastv, 36);
        // saturation on the 400/0 instance
        do_clear();
        c = snv;
        send(0); send(700); send(1400); send(604); send(1304);
        idle(4);
        chk("sat_count", snv - c, 1);
`ifdef VELEST_SATURATE_EN
        chk("sat_value", slast, 32767);
`else
        chk("sat_value", slast, 17856);
`endif
        chk("sat_main_value", lastv, 2537);
        // async reset one cycle after a sample
        c = nv;
        @(negedge clk);
        vif.i_valid = 1'b1;
        vif.i_value = 16'd100;
        @(negedge clk);
        vif.i_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_o_value", int'(vif.o_value), 0);
        chk("mrst_o_ready", int'(vif.o_ready), 0);
        rst = 1'b0;
        idle(6);
        chk("mrst_no_out", nv - c, 0);
        chk("mrst_o_valid", int'(vif.o_valid), 0);
        chk("mrst_o_err", int'(vif.o_err), 0);
        chk("mrst_value_hold", int'(vif.o_value), 0);
        chk("mrst_state", int'(dut.state), int'(IDLE));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/velocity_estimator.md
# velocity_estimator

Parametrised encoder velocity estimator. It takes strobed absolute position samples from a rotary encoder counter of modulus `MODULUS`, computes a signed, wrap-aware per-sample difference, averages it over a power-of-two window, and scales the result by a shift-add constant. It sits between the position counter and the speed-control loop, delivering one signed velocity word per accepted sample once the window is full.

## Interface
- `W`, 16: width of position input and velocity output.
- `MODULUS`, 1496: counts per revolution; legal positions are 0..MODULUS-1.
- `AVG_LOG2`, 2: averaging window depth N = 2^AVG_LOG2 (0 gives no averaging).
- `SCALE_NUM`, 29: scale numerator (unsigned, ≥1).
- `SCALE_SHIFT`, 3: scale denominator exponent; default scale = 29/8 = 3.625.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_clear`  in  1  synchronous flush of history; the block returns to IDLE.
- `i_valid`  in  1  position sample strobe.
- `i_value`  in  W  unsigned position.
- `o_valid`  out  1  one-cycle velocity strobe.
- `o_value`  out  W  signed velocity (two's complement).
- `o_err`  out  1  one-cycle pulse: rejected out-of-range sample.
- `o_ready`  out  1  high in RUN state; the window is full.

## Operation
- FSM states:
  - IDLE: no previous sample.
  - FILL: fewer than N diffs stored.
  - RUN: window full.
- IDLE + accepted sample: store it as `prev` and go to FILL. No diff is computed.
- FILL/RUN + accepted sample: compute diff = cur − prev modulo `MODULUS`, with `prev` ← cur.
  - raw = cur − prev, at signed W+1 bits.
  - If raw > MODULUS/2 (integer division), raw −= MODULUS.
  - If raw < −(MODULUS/2), raw += MODULUS.
  - Result: +MODULUS/2 is kept positive; −MODULUS/2 is kept negative.
- Averaging:
  - Ring buffer of N signed diffs, plus a running sum of width W+1+AVG_LOG2.
  - Each update: sum ← sum + new − oldest. The buffer is zeroed on reset and on clear.
  - A fill counter moves the FSM FILL→RUN on the N-th stored diff.
- Scaling:
  - avg = sum >>> AVG_LOG2 (arithmetic, floor).
  - prod = avg × SCALE_NUM, at full width.
  - vel = prod >>> SCALE_SHIFT (floor toward −∞).
- Output: vel is reduced to W bits (see Configuration). `o_valid` is asserted only for diffs processed while RUN is reached or held, so the N-th diff is the first output.
- Rejected sample (`i_valid` with `i_value` ≥ MODULUS):
  - `o_err` pulses.
  - State, `prev`, buffer and outputs are unchanged.
- `i_clear` together with `i_valid`: clear wins, and the sample is then accepted as the new `prev` (state goes to FILL).

## Timing
- Reset values: `o_valid`=0, `o_value`=0, `o_err`=0, `o_ready`=0; FSM=IDLE; `prev`, buffer, sum and counter all 0.
- Pipeline has three register stages: diff, sum/avg, scale/output.
- `o_valid`/`o_value` update on the 3rd rising edge after the edge that samples `i_valid`.
- `o_err` is registered 1 edge after the sampling edge.
- Full throughput: `i_valid` may be high every cycle. No backpressure.
- `o_value` holds its last value between strobes.
- `i_clear` kills in-flight pipeline strobes. No `o_valid` is produced for samples taken before the clear.
- Async reset mid-pipeline discards all in-flight data.

## Configuration
- `VELEST_SATURATE_EN` defined: vel is clamped to [−2^(W−1), 2^(W−1)−1].
- `VELEST_SATURATE_EN` undefined: vel is truncated to its low W bits (two's-complement wrap).

## Structure
- Package `velest_pkg`:
  - FSM state enum (IDLE, FILL, RUN).
  - Localparam helpers for diff/sum/product widths, derived from W, AVG_LOG2 and SCALE_NUM.
- Sub-module `velest_moddiff`: registered modular signed difference (stage 1), parametrised by W and MODULUS.

## Test plan
Default parameters unless stated.
- Constant speed: positions 0,10,20,30,40 → no `o_valid` for the first four samples; the 5th sample gives `o_value`=36 (floor of 10×3.625) and `o_ready`=1.
- Forward wrap:
  - Input: positions 1450,1460,1470,1480,1490,4.
  - Expected: the last sample gives diff +10, output 36.
  - Expected: no discontinuity in the sequence.
- Reverse: positions 40,30,20,10,0 → `o_value`=−37 (0xFFDB).
- Saturation: SCALE_NUM=400, SCALE_SHIFT=0, positions 0,700,1400,604,1304.
  - With `VELEST_SATURATE_EN`: 32767.
  - Without `VELEST_SATURATE_EN`: 17856 (280000 mod 65536).
- Error and clear:
  - Position 1496 mid-stream → `o_err` pulse, no state change, and the next valid output is identical to a run without that sample.
  - `i_clear`+`i_valid` in RUN → FILL, `o_ready`=0, and no output until N further diffs.
- Reset mid-stream: assert `i_reset` 1 cycle after `i_valid` → all outputs 0, no `o_valid` emerges, and the FSM is in IDLE.
